seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised multi-cycle shift/rotate unit for the datapath ALU, the successor to the single-bit serial shift-left register. It takes a WIDTH-bit operand, a shift amount and a mode, and shifts by one bit position per clock through a start/busy/done handshake. It supports logical, arithmetic, rotate and serial-fill modes. The result is held in an internal register that drives `result` continuously.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 2
- SHAMT_W, $clog2(WIDTH): shift-amount width
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request; sampled only in IDLE
- mode  input  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101 SHLS (shift left, fill from serial_in), 110/111 reserved
- operand  input  WIDTH  value loaded on an accepted start
- shamt  input  SHAMT_W  shift count, 0..WIDTH-1; sampled with start
- serial_in  input  1  fill bit for SHLS
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  single-cycle completion pulse
- result  output  WIDTH  shift register contents

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Registers are latched on the accepted start: the operand register, a down-counter, and the mode.
- **IDLE, start=1:** load operand; counter = shamt.
  - Next state is SHIFT if shamt ≠ 0.
  - Next state is DONE if shamt = 0, or if the mode is reserved.
- **SHIFT:** each edge performs one 1-bit step, then decrements the counter. After the step taken with counter = 1, next state is DONE.
- **Step rules** for register X:
  - SHL: X ← {X[W-2:0], 0}.
  - SHR: X ← {0, X[W-1:1]}.
  - SHRA: X ← {X[W-1], X[W-1:1]}.
  - ROL: X ← {X[W-2:0], X[W-1]}.
  - ROR: X ← {X[0], X[W-1:1]}.
  - SHLS: X ← {X[W-2:0], serial_in}, with serial_in sampled on that edge.
- **Reserved modes:** pass-through; result = operand.
- **DONE:** done=1 for exactly one cycle; next state is IDLE.
- **result:** equals X at all times. It changes only on load and on shift steps, and holds its value through DONE and IDLE until the next accepted start.
- **Start while busy:** ignored. No queuing; operand, shamt and mode inputs are don't-care.
- **Start in the IDLE cycle directly after DONE:** accepted normally, giving back-to-back operation.
- **Mode and shamt:** captured at start; later input changes have no effect on the operation in flight.

## Timing
- **Reset (reset=0, asynchronous):** state=IDLE, result=0, busy=0, done=0, counter=0.
  - Takes effect immediately, including mid-SHIFT; the operation in flight is discarded.
  - Reset release is synchronous to the next edge.
- **Start accepted at edge E0:**
  - busy goes high after E0.
  - done is high in the cycle after edge E0+shamt; for shamt=0 that is the cycle right after E0.
  - busy drops with done's falling edge (after edge E0+shamt+1).
- **Latency:** shamt+1 cycles from the accepting edge to IDLE; throughput is one operation per shamt+2 cycles.
- **Final result:** valid from the first cycle done is high.

## Configuration
- **SEQ_SHIFTER_BARREL_EN defined:** SHIFT state is removed.
  - The full shift is computed combinationally and loaded into X at edge E0.
  - Next state is always DONE, so done is high in the cycle after E0 regardless of shamt.
  - SHLS fills all vacated bits with the serial_in value sampled at E0.
- **Undefined (default):** sequential one-bit-per-cycle behaviour as described above.
- Either way, results are identical for all modes except SHLS when serial_in varies during the operation.

## Test plan
- **Long logical shift:** SHL, operand 0x0000_0001, shamt 31 → busy for 32 cycles, done in the cycle after E0+31, result 0x8000_0000. Barrel build: done in the cycle after E0.
- **Arithmetic and rotate modes:**
  - SHRA 0x8000_00F0, shamt 4 → 0xF800_000F.
  - ROL 0x8000_0001, shamt 4 → 0x0000_0018.
  - ROR 0x0000_0001, shamt 1 → 0x8000_0000.
  - SHR 0x8000_0000, shamt 31 → 0x0000_0001.
- **Zero shift, ignored start, back-to-back:**
  - shamt 0, operand 0x1234_5678 → done in the cycle after E0, result 0x1234_5678.
  - start pulsed while busy with different operand → ignored.
  - start in the IDLE cycle after DONE → accepted.
- **Serial fill:** SHLS, operand 0, shamt 3, serial_in held 1 → 0x0000_0007. Sequential build: serial_in = 1,0,1 on successive edges → 0x0000_0005.
- **Asynchronous reset mid-operation:** reset driven low mid-SHIFT, between clock edges → result 0, busy 0, done 0 before the next edge. After release, a new start completes correctly.
- **Reserved mode:** mode 110, operand 0xDEAD_BEEF, shamt 9 → done in the cycle after E0, result 0xDEAD_BEEF.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: SHL/SHR/SHRA/ROL/ROR/SHLS, one bit per clock.
// Latency: shamt+1 cycles from the accepting edge back to IDLE (1 with SEQ_SHIFTER_BARREL_EN).
// No backpressure: start is honoured only in IDLE and dropped while busy. Macro: SEQ_SHIFTER_BARREL_EN.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               serial_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [2:0] MODE_SHL  = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHRA = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_SHLS = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x;
  logic             mode_rsvd;

`ifndef SEQ_SHIFTER_BARREL_EN
  logic [SHAMT_W-1:0] cnt;
  logic [2:0]         mode_q;
`endif

  // Modes 110/111 are reserved and pass the operand through untouched.
  assign mode_rsvd = mode[2] & mode[1];
  assign result    = x;

  // Single 1-bit step for every supported mode; unknown modes hold the value.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                            input logic [2:0]       m,
                                            input logic             fill);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SHL:  r = {v[WIDTH-2:0], 1'b0};
      MODE_SHR:  r = {1'b0, v[WIDTH-1:1]};
      MODE_SHRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
      MODE_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROR:  r = {v[0], v[WIDTH-1:1]};
      MODE_SHLS: r = {v[WIDTH-2:0], fill};
      default:   r = v;
    endcase
    return r;
  endfunction

`ifdef SEQ_SHIFTER_BARREL_EN
  // Full shift in one go: repeat the 1-bit step shamt times, so SHLS fills
  // every vacated bit with the same serial_in value.
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0]   v,
                                              input logic [2:0]         m,
                                              input logic [SHAMT_W-1:0] s,
                                              input logic               fill);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (i < int'(s)) r = step(r, m, fill);
    end
    return r;
  endfunction
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: zero shifts and reserved modes go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef SEQ_SHIFTER_BARREL_EN
          state_nxt = ST_DONE;
`else
          if (mode_rsvd || shamt == '0) state_nxt = ST_DONE;
          else                          state_nxt = ST_SHIFT;
`endif
        end
      end
`ifndef SEQ_SHIFTER_BARREL_EN
      ST_SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of the state.
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Datapath: load on accepted start, step while shifting, hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0;
`ifndef SEQ_SHIFTER_BARREL_EN
      cnt    <= '0;
      mode_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef SEQ_SHIFTER_BARREL_EN
            x <= mode_rsvd ? operand : barrel(operand, mode, shamt, serial_in);
`else
            x      <= operand;
            cnt    <= shamt;
            mode_q <= mode;
`endif
          end
        end
`ifndef SEQ_SHIFTER_BARREL_EN
        ST_SHIFT: begin
          x   <= step(x, mode_q, serial_in);
          cnt <= cnt - SHAMT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=32): latency, results, ignored start,
// back-to-back starts, serial fill, reserved modes and asynchronous reset.
// Works for both the sequential and the SEQ_SHIFTER_BARREL_EN builds.
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        serial_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_res = '0;

  seq_shifter #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .operand   (operand),
    .shamt     (shamt),
    .serial_in (serial_in),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE and follow it to its done cycle.
  // ser_pat[k] is the serial_in value for the shift step at edge E0+k+1
  // (ser_pat[0] is also presented at E0). poke pulses a junk start in cycle 2.
  task automatic run_op(input string name, input logic [2:0] m, input logic [31:0] op,
                        input logic [4:0] sa, input logic [7:0] ser_pat, input bit poke,
                        input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit fin;
    @(negedge clock);
    check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_idle_done"}, {31'd0, done}, 32'd0);
    check({name, "_hold"}, result, last_res);
    start = 1'b1; mode = m; operand = op; shamt = sa; serial_in = ser_pat[0];
    @(negedge clock);
    start = 1'b0;
    n = 1;
    fin = 1'b0;
    check({name, "_busy_e1"}, {31'd0, busy}, 32'd1);
    while (!fin) begin
      if (n <= 8) serial_in = ser_pat[n-1];
      if (poke) begin
        start = (n == 2);
        if (n == 2) begin
          operand = 32'hFFFF_FFFF; mode = 3'b100; shamt = 5'd1;
        end
      end
      if (done || n >= 100) fin = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    check({name, "_latency"}, n, exp_lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_busy_done"}, {31'd0, busy}, 32'd1);
    last_res = exp_res;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = '0; operand = '0; shamt = '0; serial_in = 1'b0;
    @(negedge clock);
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    run_op("shl31",  3'b000, 32'h0000_0001, 5'd31, 8'h00, 1'b0, 32'h8000_0000, BARREL ? 1 : 32);
    run_op("shra4",  3'b010, 32'h8000_00F0, 5'd4,  8'h00, 1'b0, 32'hF800_000F, BARREL ? 1 : 5);
    run_op("rol4",   3'b011, 32'h8000_0001, 5'd4,  8'h00, 1'b0, 32'h0000_0018, BARREL ? 1 : 5);
    run_op("ror1",   3'b100, 32'h0000_0001, 5'd1,  8'h00, 1'b0, 32'h8000_0000, BARREL ? 1 : 2);
    run_op("shr31",  3'b001, 32'h8000_0000, 5'd31, 8'h00, 1'b0, 32'h0000_0001, BARREL ? 1 : 32);
    run_op("zero",   3'b000, 32'h1234_5678, 5'd0,  8'h00, 1'b0, 32'h1234_5678, 1);
    run_op("ignore", 3'b000, 32'h0000_000F, 5'd4,  8'h00, 1'b1, 32'h0000_00F0, BARREL ? 1 : 5);
    run_op("b2b",    3'b100, 32'h0000_0002, 5'd1,  8'h00, 1'b0, 32'h0000_0001, BARREL ? 1 : 2);
    run_op("shls1",  3'b101, 32'h0000_0000, 5'd3,  8'hFF, 1'b0, 32'h0000_0007, BARREL ? 1 : 4);
    run_op("shls101",3'b101, 32'h0000_0000, 5'd3,  8'h05, 1'b0,
           BARREL ? 32'h0000_0007 : 32'h0000_0005, BARREL ? 1 : 4);
    run_op("rsvd6",  3'b110, 32'hDEAD_BEEF, 5'd9,  8'h00, 1'b0, 32'hDEAD_BEEF, 1);
    run_op("rsvd7",  3'b111, 32'hCAFE_F00D, 5'd3,  8'h00, 1'b0, 32'hCAFE_F00D, 1);

    // Asynchronous reset between edges while an operation is under way.
    @(negedge clock);
    start = 1'b1; mode = 3'b000; operand = 32'h0000_000F; shamt = 5'd10;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre_rst_busy", {31'd0, busy}, BARREL ? 32'd0 : 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    last_res = 32'd0;

    run_op("after_rst", 3'b010, 32'h4000_0000, 5'd2, 8'h00, 1'b0, 32'h1000_0000, BARREL ? 1 : 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
